multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle sequencer for the RV32I register/ALU datapath.
//  - Fetches instructions over an imem valid handshake, decodes them and generates the immediate.
//  - Drives the datapath controls: FS, CW4_2, and the register read/write addresses.
//  - Runs load/store over a dmem valid handshake, resolves BEQ/BNE from ZCNV and owns the PC.
//  - Supported: R-type ALU, I-type ALU, LW, SW, BEQ, BNE. Any other encoding halts the core.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  CHECK_ALIGN 1              1: a taken-branch target with bits[1:0]!=0 -> HALT, illegal=1
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   asynchronous, active-low reset
//  imem_req     out  1   instruction fetch request, address = pc
//  imem_rdata   in   32  instruction word, valid when imem_valid=1
//  imem_valid   in   1   fetch completes on the cycle this is 1 while imem_req=1
//  dmem_req     out  1   data access request; address comes from datapath o_ALU
//  dmem_we      out  1   1=store (LW:0); meaningful only while dmem_req=1
//  dmem_valid   in   1   access completes on the cycle this is 1 while dmem_req=1
//  o_ALU        in   32  datapath ALU result (unused internally except by tests)
//  ZCNV         in   4   datapath flags {Z,C,N,V}; Z=ZCNV[3]
//  FS           out  4   ALU function select
//  CW4_2        out  3   {s_reg_imm_ALU_B, s_ALU_dmem_wregdata, sig_w_ctrl_reg}
//  o_imm        out  32  sign-extended immediate (I/S/B format per opcode)
//  r_addr_reg1  out  5   IR[19:15]
//  r_addr_reg2  out  5   IR[24:20]
//  w_addr_reg   out  5   IR[11:7]
//  pc           out  32  current instruction address
//  halted       out  1   1 in HALT state
//  illegal      out  1   sticky; 1 if HALT was caused by illegal opcode/funct or misalignment
// BEHAVIOUR
//  Reset (rst=0, async)
//   - pc=RESET_PC, IR=0, state=FETCH.
//   - dmem_req=0, dmem_we=0, CW4_2=3'b000, FS=0, o_imm=0, halted=0, illegal=0.
//   - imem_req goes high in the first cycle after rst rises.
//   - rst asserted mid-access aborts the access; no register write or store completes.
//  States: FETCH -> DECODE -> EXEC -> {FETCH | MEM} ; MEM -> FETCH ; any -> HALT (absorbing)
//  FETCH
//   - imem_req=1, held until imem_valid.
//   - On imem_valid: IR<=imem_rdata, go DECODE.
//   - Zero-wait memory means 1 cycle.
//  DECODE (1 cycle)
//   - Register addresses and o_imm are driven from IR; sig_w_ctrl_reg=0.
//   - Opcode not in {0110011,0010011,0000011,0100011,1100011} -> HALT, illegal=1.
//   - Opcode 1100011 with funct3 not 000/001 -> HALT, illegal=1.
//  FS and selector rules (FS/selectors held constant through DECODE, EXEC and MEM)
//   - R-type: FS={IR[14:12],IR[30]}, s_reg_imm_ALU_B=0.
//   - I-ALU: FS={IR[14:12], IR[30]&(IR[14:12]==3'b101)}, s_reg_imm_ALU_B=1.
//   - LW/SW: FS=4'b0000 (add), s_reg_imm_ALU_B=1.
//   - BEQ/BNE: FS=4'b0001 (sub), s_reg_imm_ALU_B=0.
//  EXEC (1 cycle)
//   - R/I-ALU: sig_w_ctrl_reg=1 and s_ALU_dmem_wregdata=0 for exactly this cycle; pc<=pc+4; go FETCH.
//   - Branch: taken = BEQ?Z:~Z.
//     - Taken: pc<=pc+imm_b. Internal adder; the datapath ALU is busy comparing.
//     - Not taken: pc<=pc+4.
//     - Taken with CHECK_ALIGN=1 and target[1:0]!=0: HALT, illegal=1, pc unchanged.
//     - No register write.
//   - LW/SW: go MEM.
//  MEM
//   - dmem_req=1 and dmem_we=(SW) until dmem_valid.
//   - LW: on the dmem_valid cycle only, sig_w_ctrl_reg=1 and s_ALU_dmem_wregdata=1.
//   - On dmem_valid: pc<=pc+4, dmem_req drops next cycle, go FETCH.
//  HALT
//   - All requests and sig_w_ctrl_reg are 0; pc frozen; halted=1.
//   - Exit only by reset.
//  Arithmetic and width rules
//   - PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
//   - Immediates are sign-extended from IR[31].
//     - I: IR[31:20].
//     - S: {IR[31:25],IR[11:7]}.
//     - B: {IR[31],IR[7],IR[30:25],IR[11:8],1'b0}.
//  Handshakes
//   - Wait states are unbounded; outputs are stable while waiting.
//   - imem_valid/dmem_valid seen while the matching req is 0 are ignored.
//  Latency
//   - ALU op and branch: 3 cycles.
//   - LW/SW: 4 cycles at zero wait, plus memory wait cycles.
// TESTING
//  1. Reset release, zero-wait imem, ADDI x1,x0,5 (32'h00500093):
//     - imem_req on cycle 1, CW4_2=3'b101 in EXEC, w_addr_reg=1, o_imm=5, pc=4 after 3 cycles.
//  2. SUB x3,x1,x2 (32'h402081B3):
//     - FS=4'b0001, CW4_2=3'b001 on the EXEC cycle only, r_addr 1/2, w_addr 3.
//  3. LW x4,8(x0) with dmem_valid delayed 3 cycles:
//     - dmem_req high 4 cycles, dmem_we=0.
//     - CW4_2=3'b111 only on the valid cycle, pc+=4.
//  4. SW x2,-4(x1) (32'hFE20AE23):
//     - o_imm=32'hFFFF_FFFC, dmem_we=1, sig_w_ctrl_reg never 1.
//  5. BEQ imm=-8 at pc=16:
//     - ZCNV[3]=1 -> pc=8.
//     - Repeat with Z=0 -> pc=20; BNE inverted.
//  6. Opcode 7'b1111111, and rst pulsed low during an MEM wait:
//     - Illegal: HALT, halted=1, illegal=1, no further imem_req.
//     - Reset pulse: async clear to pc=RESET_PC with no write.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for an RV32I register/ALU datapath.
// Owns PC and IR, resolves BEQ/BNE from ZCNV and halts for good on any unsupported encoding.
module multicycle_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_valid,
    input  logic [31:0] o_ALU,
    input  logic [3:0]  ZCNV,
    output logic [3:0]  FS,
    output logic [2:0]  CW4_2,
    output logic [31:0] o_imm,
    output logic [4:0]  r_addr_reg1,
    output logic [4:0]  r_addr_reg2,
    output logic [4:0]  w_addr_reg,
    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state;
    logic [31:0] ir;
    logic        sel_b;
    logic        wr_alu;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_r, is_i, is_lw, is_sw, is_br, br_ok, legal;
    logic [31:0] imm_i, imm_s, imm_b, br_target;
    logic        br_taken, lw_write;
    logic        unused_inputs;

    // FS and the B-operand select are set when the word is captured, so they are
    // already stable during DECODE and stay put through EXEC and MEM.
    function automatic logic [4:0] fetch_ctrl(input logic [31:0] w);
        logic [4:0] c;
        c = 5'b0_0000;
        case (w[6:0])
            OP_R:              c = {w[14:12], w[30], 1'b0};
            OP_I:              c = {w[14:12], w[30] & (w[14:12] == 3'b101), 1'b1};
            OP_LOAD, OP_STORE: c = 5'b0000_1;
            OP_BRANCH:         c = 5'b0001_0;
            default:           c = 5'b0000_0;
        endcase
        return c;
    endfunction

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];

    assign is_r  = (opcode == OP_R);
    assign is_i  = (opcode == OP_I);
    assign is_lw = (opcode == OP_LOAD);
    assign is_sw = (opcode == OP_STORE);
    assign is_br = (opcode == OP_BRANCH);
    assign br_ok = is_br && (funct3 == 3'b000 || funct3 == 3'b001);
    assign legal = is_r || is_i || is_lw || is_sw || br_ok;

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    always_comb begin
        o_imm = 32'h0000_0000;
        case (opcode)
            OP_I, OP_LOAD: o_imm = imm_i;
            OP_STORE:      o_imm = imm_s;
            OP_BRANCH:     o_imm = imm_b;
            default:       o_imm = 32'h0000_0000;
        endcase
    end

    assign r_addr_reg1 = ir[19:15];
    assign r_addr_reg2 = ir[24:20];
    assign w_addr_reg  = ir[11:7];

    // The datapath ALU is busy comparing during a branch, so the target uses its own adder.
    assign br_target = pc + imm_b;
    assign br_taken  = (funct3 == 3'b000) ? ZCNV[3] : ~ZCNV[3];

    // A load writes back only on the cycle its data arrives, hence the combinational term.
    assign lw_write = (state == S_MEM) && is_lw && dmem_req && dmem_valid;
    assign CW4_2    = {sel_b, lw_write, wr_alu | lw_write};

    assign state_dbg     = state;
    assign unused_inputs = ^{o_ALU, ZCNV[2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= 32'h0000_0000;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            FS       <= 4'h0;
            sel_b    <= 1'b0;
            wr_alu   <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_valid) begin
                        ir            <= imem_rdata;
                        {FS, sel_b}   <= fetch_ctrl(imem_rdata);
                        imem_req      <= 1'b0;
                        state         <= S_DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        wr_alu <= is_r || is_i;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wr_alu <= 1'b0;
                    if (is_r || is_i) begin
                        pc       <= pc + 32'd4;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else if (is_br) begin
                        if (br_taken && CHECK_ALIGN && (br_target[1:0] != 2'b00)) begin
                            state   <= S_HALT;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                        end else begin
                            pc       <= br_taken ? br_target : pc + 32'd4;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end else begin
                        dmem_req <= 1'b1;
                        dmem_we  <= is_sw;
                        state    <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (dmem_valid) begin
                        pc       <= pc + 32'd4;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    wr_alu   <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed plus random instruction streams for multicycle_controller, checked against an
// instruction-level model of PC, control words, immediates and handshake timing.
module tb_multicycle_controller;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_valid = 1'b0;
    logic [31:0] o_ALU = '0;
    logic [3:0]  ZCNV = '0;
    logic [3:0]  FS;
    logic [2:0]  CW4_2;
    logic [31:0] o_imm;
    logic [4:0]  r_addr_reg1, r_addr_reg2, w_addr_reg;
    logic [31:0] pc;
    logic        halted, illegal;
    logic [2:0]  state_dbg;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pc;
    bit          m_halted;

    multicycle_controller #(.RESET_PC(RESET_PC), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_valid(dmem_valid),
        .o_ALU(o_ALU), .ZCNV(ZCNV), .FS(FS), .CW4_2(CW4_2), .o_imm(o_imm),
        .r_addr_reg1(r_addr_reg1), .r_addr_reg2(r_addr_reg2), .w_addr_reg(w_addr_reg),
        .pc(pc), .halted(halted), .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 R-ALU, 1 I-ALU, 2 LW, 3 SW, 4 branch, 5 unsupported
    function automatic int kind_of(input logic [31:0] w);
        case (w[6:0])
            7'b0110011: return 0;
            7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return (w[14:12] == 3'b000 || w[14:12] == 3'b001) ? 4 : 5;
            default:    return 5;
        endcase
    endfunction

    function automatic logic [3:0] exp_fs(input logic [31:0] w, input int k);
        case (k)
            0:       return {w[14:12], w[30]};
            1:       return {w[14:12], w[30] && (w[14:12] == 3'd5)};
            4:       return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] w, input int k);
        int v;
        case (k)
            1, 2:    v = int'({w[31:20], 20'b0}) >>> 20;
            3:       v = int'({w[31:25], w[11:7], 20'b0}) >>> 20;
            4:       v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0}) >>> 19;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [12:0] imm;
        imm = 13'(off);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic noise();
        o_ALU = $urandom;
        ZCNV  = 4'($urandom);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst        = 1'b1;
        imem_valid = 1'($urandom_range(0, 1));
        #1;
        check("rel_imem_req", imem_req, 1'b0);
        check("rel_pc", pc, RESET_PC);
        m_pc     = RESET_PC;
        m_halted = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_pc", pc, RESET_PC);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_cw", CW4_2, 3'b000);
        check("rst_fs", FS, 4'h0);
        check("rst_imm", o_imm, 32'h0);
        check("rst_dmem", {dmem_req, dmem_we}, 2'b00);
        check("rst_imem_req", imem_req, 1'b0);
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    task automatic check_halt(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            imem_valid = 1'($urandom_range(0, 1));
            dmem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            noise();
            #1;
            check("halt_halted", halted, 1'b1);
            check("halt_illegal", illegal, 1'b1);
            check("halt_req", {imem_req, dmem_req}, 2'b00);
            check("halt_wr", CW4_2[0], 1'b0);
            check("halt_pc", pc, m_pc);
        end
    endtask

    // Runs one instruction from its first FETCH cycle; iw/dw are memory wait states.
    task automatic exec_instr(input logic [31:0] w, input int iw, input int dw,
                              input bit z, input bit abort);
        int          k;
        logic        selb, lw_v;
        logic [31:0] tgt;
        bit          taken;
        k    = kind_of(w);
        selb = (k == 1 || k == 2 || k == 3);
        for (int c = 0; c <= iw; c++) begin
            @(negedge clk);
            imem_valid = (c == iw);
            imem_rdata = (c == iw) ? w : $urandom;
            dmem_valid = 1'($urandom_range(0, 1));
            noise();
            #1;
            check("fetch_req", imem_req, 1'b1);
            check("fetch_pc", pc, m_pc);
            check("fetch_dreq", dmem_req, 1'b0);
            check("fetch_wr", CW4_2[0], 1'b0);
            check("fetch_illegal", {halted, illegal}, 2'b00);
        end
        @(negedge clk);
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        dmem_valid = 1'($urandom_range(0, 1));
        noise();
        #1;
        check("dec_imem_req", imem_req, 1'b0);
        check("dec_raddr", {r_addr_reg1, r_addr_reg2}, {w[19:15], w[24:20]});
        check("dec_waddr", w_addr_reg, w[11:7]);
        if (k == 5) begin
            @(negedge clk);
            #1;
            check("ill_halted", {halted, illegal}, 2'b11);
            check("ill_imem_req", imem_req, 1'b0);
            check("ill_pc", pc, m_pc);
            m_halted = 1'b1;
            return;
        end
        check("dec_fs", FS, exp_fs(w, k));
        check("dec_cw", CW4_2, {selb, 2'b00});
        if (k != 0) check("dec_imm", o_imm, exp_imm(w, k));

        @(negedge clk);
        imem_valid = 1'($urandom_range(0, 1));
        dmem_valid = 1'($urandom_range(0, 1));
        o_ALU      = $urandom;
        ZCNV       = {z, 3'($urandom)};
        #1;
        check("exe_fs", FS, exp_fs(w, k));
        check("exe_cw", CW4_2, {selb, 1'b0, (k <= 1)});
        check("exe_req", {imem_req, dmem_req}, 2'b00);
        if (k <= 1) begin
            m_pc = m_pc + 32'd4;
            return;
        end
        if (k == 4) begin
            taken = (w[14:12] == 3'b000) ? z : !z;
            tgt   = m_pc + exp_imm(w, k);
            if (taken && (tgt % 4 != 0)) begin
                @(negedge clk);
                #1;
                check("mis_halted", {halted, illegal}, 2'b11);
                check("mis_pc", pc, m_pc);
                check("mis_imem_req", imem_req, 1'b0);
                m_halted = 1'b1;
            end else begin
                m_pc = taken ? tgt : m_pc + 32'd4;
            end
            return;
        end
        for (int c = 0; c <= dw; c++) begin
            @(negedge clk);
            dmem_valid = (c == dw);
            imem_valid = 1'($urandom_range(0, 1));
            noise();
            if (abort && c == 1) begin
                dmem_valid = 1'b1;
                rst        = 1'b0;
                #1;
                check("abort_pc", pc, RESET_PC);
                check("abort_cw", CW4_2, 3'b000);
                check("abort_dmem", {dmem_req, dmem_we}, 2'b00);
                m_pc = RESET_PC;
                return;
            end
            #1;
            lw_v = (k == 2) && (c == dw);
            check("mem_req", {dmem_req, imem_req}, 2'b10);
            check("mem_we", dmem_we, (k == 3));
            check("mem_fs", FS, 4'b0000);
            check("mem_cw", CW4_2, {1'b1, lw_v, lw_v});
            check("mem_pc", pc, m_pc);
        end
        m_pc = m_pc + 32'd4;
    endtask

    function automatic logic [31:0] rand_instr();
        int          r;
        int          off;
        logic [31:0] w;
        r = $urandom_range(0, 19);
        w = $urandom;
        if (r <= 4) begin
            w = enc_r({1'b0, w[30], 5'b0}, w[24:20], w[19:15], w[14:12], w[11:7]);
        end else if (r <= 9) begin
            w = {w[31:7], 7'b0010011};
        end else if (r <= 12) begin
            w = {w[31:7], 7'b0000011};
        end else if (r <= 15) begin
            w = {w[31:7], 7'b0100011};
        end else if (r <= 18) begin
            off = $urandom_range(0, 20) * 4 - 40;
            if ($urandom_range(0, 7) == 0) off = off + 2;
            w = enc_b(off, w[24:20], w[19:15], {2'b00, w[12]});
        end else begin
            w = {w[31:7], 7'b1110011};
        end
        return w;
    endfunction

    initial begin
        m_pc     = RESET_PC;
        m_halted = 1'b0;
        apply_reset();

        exec_instr(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 0, 0, 1'b0, 1'b0);
        exec_instr(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 1, 0, 1'b0, 1'b0);
        exec_instr(enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011), 0, 3, 1'b0, 1'b0);
        exec_instr(enc_s(12'hFFC, 5'd2, 5'd1, 3'b010), 0, 0, 1'b0, 1'b0);
        check("pc_at_16", m_pc, 32'd16);
        exec_instr(enc_b(-8, 5'd2, 5'd1, 3'b000), 0, 0, 1'b1, 1'b0);
        exec_instr(enc_i(12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011), 2, 0, 1'b0, 1'b0);
        exec_instr(enc_i(12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011), 0, 0, 1'b0, 1'b0);
        exec_instr(enc_b(-8, 5'd2, 5'd1, 3'b000), 0, 0, 1'b0, 1'b0);
        exec_instr(enc_b(-8, 5'd2, 5'd1, 3'b001), 0, 0, 1'b0, 1'b0);
        exec_instr(enc_b(-8, 5'd2, 5'd1, 3'b001), 0, 0, 1'b1, 1'b0);
        exec_instr(enc_b(-6, 5'd2, 5'd1, 3'b000), 0, 0, 1'b1, 1'b0);
        check_halt(3);
        apply_reset();

        exec_instr(enc_b(-4, 5'd0, 5'd0, 3'b000), 0, 0, 1'b1, 1'b0);
        exec_instr(enc_i(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011), 0, 0, 1'b0, 1'b0);
        exec_instr(enc_i(12'hFFF, 5'd3, 3'b101, 5'd7, 7'b0010011), 0, 0, 1'b0, 1'b0);
        exec_instr(32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
        check_halt(3);
        apply_reset();
        exec_instr(enc_b(8, 5'd1, 5'd2, 3'b010), 0, 0, 1'b1, 1'b0);
        check_halt(2);
        apply_reset();

        for (int n = 0; n < 300; n++) begin
            exec_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 1'b0);
            if (m_halted) begin
                check_halt(2);
                apply_reset();
            end
        end

        exec_instr(enc_i(12'd4, 5'd0, 3'b000, 5'd9, 7'b0010011), 0, 0, 1'b0, 1'b0);
        exec_instr(enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011), 0, 5, 1'b0, 1'b1);
        apply_reset();
        exec_instr(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 0, 0, 1'b0, 1'b0);
        exec_instr(enc_i(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011), 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
